// File: rtl/gullfaxi_pkg.sv
// rtl/gullfaxi_pkg.sv - shared types, widths and helpers for the Gullfaxi port sink
package gullfaxi_pkg;

    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        SK_IDLE,
        SK_WAIT_START,
        SK_RECV,
        SK_DISCARD
    } sink_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gullfaxi_sink_buf.sv
// rtl/gullfaxi_sink_buf.sv - packet byte buffer, one write port and one asynchronous read port
module gullfaxi_sink_buf #(
    parameter int DEPTH    = 64,
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 9
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [LOGDEPTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]    i_wr_data,
    input  logic [LOGDEPTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]    o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/gullfaxi_port_sink.sv
// rtl/gullfaxi_port_sink.sv - Gullfaxi output-port receiver: grant, capture, frame check, commit to byte stream
module gullfaxi_port_sink
    import gullfaxi_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int LOGDEPTH  = 6,
    parameter int MAXLENGTH = 12,
    parameter int TIMEOUT   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic [LEN_W-1:0]  in_length,
    output logic              in_grant,
    input  logic              in_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_end,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
);

    localparam int PW    = LOGDEPTH + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT - 1);

    sink_state_t        r_state, w_next_state;
    logic [PW-1:0]      r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pkt_base;
    logic [LEN_W-1:0]   r_len, r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_started;
    logic               r_grant;
    logic [15:0]        r_pkt_count, r_err_count;

    logic [PW-1:0]      w_used, w_free;
    logic               w_len_legal, w_fits, w_last_byte;
    logic               w_grant, w_wr_en, w_wr_last, w_commit, w_err, w_rollback;
    logic [DATA_W:0]    w_rd_word;
    logic               w_rd_fire;

    // Free space uses the registered read pointer, so a same-cycle read never lets a grant overcommit.
    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_free      = DEPTH_P - w_used;
    assign w_len_legal = (in_length != '0) && (in_length <= LEN_W'(MAXLENGTH));
    assign w_fits      = w_free >= PW'(in_length);
    assign w_last_byte = (r_cnt + LEN_W'(1)) == r_len;

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_last    = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_rollback   = 1'b0;
        case (r_state)
            SK_IDLE: begin
                if (in_req && !w_len_legal) begin
                    w_grant      = 1'b1;
                    w_next_state = SK_DISCARD;
                end else if (in_req && w_fits) begin
                    w_grant      = 1'b1;
                    w_next_state = SK_WAIT_START;
                end
            end
            SK_WAIT_START: begin
                if (in_start) begin
                    w_wr_en = 1'b1;
                    if (r_len == LEN_W'(1)) begin
                        if (in_end) begin
                            w_wr_last = 1'b1;
                            w_commit  = 1'b1;
                        end else begin
                            w_err      = 1'b1;
                            w_rollback = 1'b1;
                        end
                        w_next_state = SK_IDLE;
                    end else if (in_end) begin
                        w_err        = 1'b1;
                        w_rollback   = 1'b1;
                        w_next_state = SK_IDLE;
                    end else begin
                        w_next_state = SK_RECV;
                    end
                end else if (r_tmo == TMO_END) begin
                    w_err        = 1'b1;
                    w_next_state = SK_IDLE;
                end
            end
            SK_RECV: begin
                // Every cycle carries a byte, so the end marker must land exactly on byte len-1.
                if (in_start || (in_end != w_last_byte)) begin
                    w_err        = 1'b1;
                    w_rollback   = 1'b1;
                    w_next_state = SK_IDLE;
                end else begin
                    w_wr_en = 1'b1;
                    if (in_end) begin
                        w_wr_last    = 1'b1;
                        w_commit     = 1'b1;
                        w_next_state = SK_IDLE;
                    end
                end
            end
            SK_DISCARD: begin
                if ((r_started || in_start) && in_end) begin
                    w_err        = 1'b1;
                    w_next_state = SK_IDLE;
                end else if (!r_started && !in_start && (r_tmo == TMO_END)) begin
                    w_err        = 1'b1;
                    w_next_state = SK_IDLE;
                end
            end
            default: w_next_state = SK_IDLE;
        endcase
    end

    assign out_valid = (r_rd_ptr != r_cm_ptr);
    assign w_rd_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SK_IDLE;
            r_wr_ptr    <= '0;
            r_cm_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_base  <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_started   <= 1'b0;
            r_grant     <= 1'b0;
            r_pkt_count <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_grant;
            if (w_grant) begin
                r_len      <= in_length;
                r_pkt_base <= r_wr_ptr;
                r_cnt      <= '0;
                r_tmo      <= '0;
                r_started  <= 1'b0;
            end else if (r_state == SK_WAIT_START || r_state == SK_DISCARD) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (r_state == SK_DISCARD && in_start) begin
                r_started <= 1'b1;
            end
            if (w_rollback) begin
                r_wr_ptr <= r_pkt_base;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_cnt    <= r_cnt + LEN_W'(1);
            end
            if (w_commit) begin
                r_cm_ptr    <= r_wr_ptr + PW'(1);
                r_pkt_count <= sat_inc(r_pkt_count);
            end
            if (w_err) begin
                r_err_count <= sat_inc(r_err_count);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    gullfaxi_sink_buf #(
        .DEPTH    (DEPTH),
        .LOGDEPTH (LOGDEPTH),
        .WIDTH    (DATA_W + 1)
    ) u_buf (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[LOGDEPTH-1:0]),
        .i_wr_data ({w_wr_last, in_data}),
        .i_rd_addr (r_rd_ptr[LOGDEPTH-1:0]),
        .o_rd_data (w_rd_word)
    );

    assign out_data  = out_valid ? w_rd_word[DATA_W-1:0] : '0;
    assign out_last  = out_valid ? w_rd_word[DATA_W]     : 1'b0;
    assign in_grant  = r_grant;
    assign busy      = (r_state != SK_IDLE);
    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gullfaxi_port_sink.sv
// tb/tb_gullfaxi_port_sink.sv - scoreboard bench for gullfaxi_port_sink
module tb_gullfaxi_port_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_req;
    logic [5:0]  in_length;
    logic        in_grant;
    logic        in_start;
    logic [7:0]  in_data;
    logic        in_end;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    gullfaxi_port_sink dut (
        .clk       (clk),
        .reset     (reset),
        .in_req    (in_req),
        .in_length (in_length),
        .in_grant  (in_grant),
        .in_start  (in_start),
        .in_data   (in_data),
        .in_end    (in_end),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] sb [$];
    int         exp_pkt  = 0;
    int         exp_err  = 0;
    bit         rand_on  = 1'b0;
    logic [7:0] pkt_bytes [0:15];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) check_eq("out_stray", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
            else check_eq("out_byte", {23'd0, out_last, out_data}, {23'd0, sb.pop_front()});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_on) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [5:0] len, input int budget, output bit got);
        got       = 1'b0;
        in_req    = 1'b1;
        in_length = len;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (in_grant) got = 1'b1;
        end
        in_req = 1'b0;
    endtask

    task automatic send(input int n, input int end_idx);
        for (int i = 0; i < n; i++) begin
            in_start = (i == 0);
            in_end   = (i == end_idx);
            in_data  = pkt_bytes[i];
            tick();
        end
        in_start = 1'b0;
        in_end   = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic good_pkt(input int len, input int budget);
        bit g;
        request(6'(len), budget, g);
        check_eq("grant", 32'(g), 1);
        for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), pkt_bytes[i]});
        tick();
        check_eq("grant_pulse", 32'(in_grant), 0);
        send(len, len - 1);
        exp_pkt++;
    endtask

    task automatic rand_bytes();
        for (int i = 0; i < 16; i++) pkt_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 300 && (sb.size() != 0 || out_valid); k++) tick();
        check_eq("drain_sb_empty", 32'(sb.size()), 0);
        check_eq("drain_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        bit g;
        reset = 1'b1; in_req = 1'b0; in_length = '0; in_start = 1'b0;
        in_data = '0; in_end = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        check_eq("rst_grant", 32'(in_grant), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_pkt_count", 32'(pkt_count), 0);
        check_eq("rst_err_count", 32'(err_count), 0);
        reset = 1'b0;
        tick();

        // basic 4-byte packet
        out_ready = 1'b1;
        pkt_bytes[0] = 8'h11; pkt_bytes[1] = 8'h22; pkt_bytes[2] = 8'h33; pkt_bytes[3] = 8'h44;
        good_pkt(4, 4);
        check_eq("pkt4_count", 32'(pkt_count), 32'(exp_pkt));
        drain();

        // buffer fill to 60 bytes, then a 5-byte request must wait for one byte of space
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            rand_bytes();
            good_pkt(12, 6);
        end
        request(6'd5, 6, g);
        check_eq("full_no_grant", 32'(g), 0);
        in_req = 1'b1; in_length = 6'd5;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("grant_wait_registered_rd", 32'(in_grant), 0);
        tick();
        check_eq("grant_after_drain", 32'(in_grant), 1);
        in_req = 1'b0;
        rand_bytes();
        for (int i = 0; i < 5; i++) sb.push_back({(i == 4), pkt_bytes[i]});
        tick();
        send(5, 4);
        exp_pkt++;
        check_eq("fill_pkt_count", 32'(pkt_count), 32'(exp_pkt));
        drain();

        // single-byte packet, start and end together
        pkt_bytes[0] = 8'hAA;
        good_pkt(1, 4);
        check_eq("len1_pkt_count", 32'(pkt_count), 32'(exp_pkt));
        drain();

        // short packet: end arrives on the second of three bytes
        rand_bytes();
        request(6'd3, 4, g);
        check_eq("short_grant", 32'(g), 1);
        tick();
        send(2, 1);
        exp_err++;
        check_eq("short_err_count", 32'(err_count), 32'(exp_err));
        check_eq("short_nothing_visible", 32'(out_valid), 0);
        check_eq("short_idle", 32'(busy), 0);
        rand_bytes();
        good_pkt(3, 4);
        drain();

        // illegal lengths are granted and discarded
        rand_bytes();
        request(6'd0, 4, g);
        check_eq("len0_grant", 32'(g), 1);
        tick();
        send(3, 2);
        exp_err++;
        check_eq("len0_err_count", 32'(err_count), 32'(exp_err));
        request(6'd13, 4, g);
        check_eq("len13_grant", 32'(g), 1);
        tick();
        send(4, 3);
        exp_err++;
        check_eq("len13_err_count", 32'(err_count), 32'(exp_err));
        check_eq("discard_nothing_visible", 32'(out_valid), 0);

        // grant then no start: abort after the timeout window
        request(6'd4, 4, g);
        check_eq("tmo_grant", 32'(g), 1);
        repeat (7) tick();
        check_eq("tmo_still_busy", 32'(busy), 1);
        tick();
        exp_err++;
        check_eq("tmo_idle", 32'(busy), 0);
        check_eq("tmo_err_count", 32'(err_count), 32'(exp_err));

        // long stream across pointer wrap with a random consumer
        rand_on = 1'b1;
        for (int p = 0; p < 20; p++) begin
            rand_bytes();
            good_pkt(12, 300);
        end
        rand_on = 1'b0;
        tick();
        drain();
        check_eq("final_pkt_count", 32'(pkt_count), 32'(exp_pkt));
        check_eq("final_err_count", 32'(err_count), 32'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
